tx_blk_dma_sched: RTL and testbench

TX_BLK_DMA_SCHED -- requirements
Module: tx_blk_dma_sched

---
 rtl/bali_lib_pkg.sv | 34 +++
 rtl/tx_blk_dma_sched_link_ctx.sv | 45 ++++
 rtl/tx_blk_dma_sched.sv | 201 ++++++++++++++++++++
 tb/tb_tx_blk_dma_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bali_lib_pkg.sv
// bali_lib_pkg: shared types and constants for the TX block DMA scheduler.
//   sched_state_t : scheduler FSM state, encoded 0..3 as reported to software
//   BLK_BEATS / TLP_BEATS / TLPS_PER_BLK / TLP_BYTES : block geometry
//   ring_depth()  : ring depth in blocks from the 8-bit register (0 means 256)
//   tlp_address() : host byte address of one TLP inside a ring
package bali_lib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

  localparam int BLK_BEATS    = 128;
  localparam int TLP_BEATS    = 8;
  localparam int TLPS_PER_BLK = 16;
  localparam int TLP_BYTES    = 256;

  localparam logic [9:0] TLP_LEN_DW = 10'd64;

  function automatic logic [8:0] ring_depth(input logic [7:0] blks);
    return (blks == 8'd0) ? 9'd256 : {1'b0, blks};
  endfunction

  // Ring base is 4KB aligned, so its low 12 bits are masked off; the sum
  // wraps silently at 64 bits.
  function automatic logic [63:0] tlp_address(input logic [63:0] base,
                                              input logic [7:0]  blk,
                                              input logic [3:0]  idx);
    return (base & ~64'hfff) + {44'b0, blk, 12'b0} + {52'b0, idx, 8'b0};
  endfunction

endpackage

// File: rtl/tx_blk_dma_sched_link_ctx.sv
// tx_blk_dma_sched_link_ctx: per-link ring context.
//   clk, rst     : clock, async active-high reset
//   blks         : ring depth register (0 means 256 blocks)
//   start        : a block for this link is being started
//   free         : host released one block of this link
//   adv          : block finished; advance the write pointer
//   wr_ptr       : ring slot the next block is written to
//   credit       : another block may be started (outstanding < depth)
module tx_blk_dma_sched_link_ctx
  import bali_lib_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] blks,
  input  logic       start,
  input  logic       free,
  input  logic       adv,
  output logic [7:0] wr_ptr,
  output logic       credit
);

  logic [8:0] depth;
  logic [8:0] wr_next;
  logic [8:0] outstanding;

  assign depth   = ring_depth(blks);
  assign credit  = (outstanding < depth);
  assign wr_next = {1'b0, wr_ptr} + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      outstanding <= '0;
    end else begin
      // >= rather than == keeps the pointer in range if depth is shrunk
      if (adv)
        wr_ptr <= (wr_next >= depth) ? 8'd0 : wr_next[7:0];
      if (start && !free)
        outstanding <= outstanding + 9'd1;
      else if (free && !start && (outstanding != 9'd0))
        outstanding <= outstanding - 9'd1;
    end
  end

endmodule

// File: rtl/tx_blk_dma_sched.sv
// tx_blk_dma_sched: moves 128-beat blocks from the link-arbiter FIFO into
// per-link host rings as 16 posted TLPs of 8 beats (256 bytes) each.
//   iCLK, iRST                  : clock, async active-high reset
//   iREG_*                      : enable, per-link ring base and depth
//   iFIFO_* / oFIFO_RD_ACK      : show-ahead data FIFO and its pop
//   iLINK_* / oBLK_DONE_PULSE   : show-ahead link-number FIFO and its pop
//   oTLP_* / iTLP_ACK           : TLP header request
//   oTX_DATA* / iTX_READY       : payload stream
//   iHOST_*                     : host returns a ring block (credit)
//   oHIP_*                      : block-written notification
//   oREG_SCHED_PS, oREG_*_CTR   : status and statistics
// Optional macro TX_BLK_DMA_SCHED_STATS_EN builds the statistics counters;
// without it the counter outputs are tied to zero.
module tx_blk_dma_sched
  import bali_lib_pkg::*;
#(
  parameter int PORTS      = 12,
  parameter int PORT_WIDTH = $clog2(PORTS)
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iREG_SCHED_EN,
  input  logic [PORTS-1:0][63:0]      iREG_RING_BASE,
  input  logic [PORTS-1:0][7:0]       iREG_RING_BLKS,
  input  logic [7:0]                  iFIFO_USED,
  input  logic                        iFIFO_FULL,
  input  logic                        iFIFO_EMPTY,
  input  logic [255:0]                iFIFO_DATA,
  input  logic [PORT_WIDTH-1:0]       iLINK_NUMBER,
  input  logic                        iLINK_FIFO_EMPTY,
  output logic                        oFIFO_RD_ACK,
  output logic                        oBLK_DONE_PULSE,
  output logic                        oHIP_BLK_DONE,
  output logic [PORT_WIDTH-1:0]       oHIP_LINK_NUMBER,
  output logic                        oTLP_REQ,
  input  logic                        iTLP_ACK,
  output logic [63:0]                 oTLP_ADDR,
  output logic [9:0]                  oTLP_LEN_DW,
  output logic [255:0]                oTX_DATA,
  output logic                        oTX_DATA_V,
  input  logic                        iTX_READY,
  input  logic                        iHOST_BLK_FREE,
  input  logic [PORT_WIDTH-1:0]       iHOST_LINK_NUMBER,
  output logic [1:0]                  oREG_SCHED_PS,
  output logic [31:0]                 oREG_STALL_CTR,
  output logic [PORTS-1:0][31:0]      oREG_BLK_CTR
);

  localparam int SLOTS = 1 << PORT_WIDTH;

  sched_state_t          state;
  logic [PORT_WIDTH-1:0] cur_link;
  logic [3:0]            tlp_idx;
  logic [2:0]            beat_cnt;
  logic                  tlp_req;
  logic                  done_pulse;
  logic [PORT_WIDTH-1:0] hip_link;
  logic [63:0]           tlp_addr;

  logic [PORTS-1:0][7:0] wr_ptr;
  logic [PORTS-1:0]      credit;
  logic [SLOTS-1:0]      credit_ext;
  logic [PORTS-1:0]      start_vec;
  logic [PORTS-1:0]      free_vec;
  logic [PORTS-1:0]      adv_vec;

  logic        blk_avail;
  logic        head_credit;
  logic        go;
  logic        start_en;
  logic        in_data;
  logic        tx_v;
  logic        rd_ack;
  logic        last_beat;
  logic [63:0] start_addr;
  logic [63:0] next_addr;

  assign blk_avail = iFIFO_FULL | ((32'(iFIFO_USED) >= BLK_BEATS) & ~iFIFO_EMPTY);

  // Padding to a power of two makes an out-of-range link number read as
  // "no credit" instead of indexing past the context array.
  assign credit_ext  = SLOTS'(credit);
  assign head_credit = credit_ext[iLINK_NUMBER];
  assign go          = iREG_SCHED_EN & blk_avail & ~iLINK_FIFO_EMPTY & head_credit;
  assign start_en    = go & (state == ST_IDLE);

  assign in_data   = (state == ST_DATA);
  assign tx_v      = in_data & ~iFIFO_EMPTY;
  assign rd_ack    = tx_v & iTX_READY;
  assign last_beat = rd_ack & (beat_cnt == 3'(TLP_BEATS - 1));

  assign start_addr = tlp_address(iREG_RING_BASE[iLINK_NUMBER], wr_ptr[iLINK_NUMBER], 4'd0);
  assign next_addr  = tlp_address(iREG_RING_BASE[cur_link], wr_ptr[cur_link], tlp_idx + 4'd1);

  for (genvar i = 0; i < PORTS; i++) begin : g_link
    assign start_vec[i] = start_en && (iLINK_NUMBER == PORT_WIDTH'(i));
    assign free_vec[i]  = iHOST_BLK_FREE && (iHOST_LINK_NUMBER == PORT_WIDTH'(i));
    assign adv_vec[i]   = (state == ST_DONE) && (cur_link == PORT_WIDTH'(i));

    tx_blk_dma_sched_link_ctx u_ctx (
      .clk    (iCLK),
      .rst    (iRST),
      .blks   (iREG_RING_BLKS[i]),
      .start  (start_vec[i]),
      .free   (free_vec[i]),
      .adv    (adv_vec[i]),
      .wr_ptr (wr_ptr[i]),
      .credit (credit[i])
    );
  end

  // The enable is only sampled in IDLE, so a block in flight always finishes.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= ST_IDLE;
      cur_link   <= '0;
      tlp_idx    <= '0;
      beat_cnt   <= '0;
      tlp_req    <= 1'b0;
      done_pulse <= 1'b0;
      hip_link   <= '0;
      tlp_addr   <= '0;
    end else begin
      done_pulse <= 1'b0;
      hip_link   <= '0;
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_HDR;
            cur_link <= iLINK_NUMBER;
            tlp_idx  <= '0;
            beat_cnt <= '0;
            tlp_req  <= 1'b1;
            tlp_addr <= start_addr;
          end
        end
        ST_HDR: begin
          if (iTLP_ACK) begin
            state    <= ST_DATA;
            tlp_req  <= 1'b0;
            beat_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (rd_ack) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (last_beat) begin
              if (tlp_idx == 4'(TLPS_PER_BLK - 1)) begin
                state      <= ST_DONE;
                done_pulse <= 1'b1;
                hip_link   <= cur_link;
              end else begin
                state    <= ST_HDR;
                tlp_idx  <= tlp_idx + 4'd1;
                tlp_req  <= 1'b1;
                tlp_addr <= next_addr;
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oFIFO_RD_ACK     = rd_ack;
  assign oTX_DATA_V       = tx_v;
  assign oTX_DATA         = in_data ? iFIFO_DATA : '0;
  assign oTLP_REQ         = tlp_req;
  assign oTLP_ADDR        = tlp_addr;
  assign oTLP_LEN_DW      = TLP_LEN_DW;
  assign oBLK_DONE_PULSE  = done_pulse;
  assign oHIP_BLK_DONE    = done_pulse;
  assign oHIP_LINK_NUMBER = hip_link;
  assign oREG_SCHED_PS    = state;

`ifdef TX_BLK_DMA_SCHED_STATS_EN
  logic [31:0]           stall_ctr;
  logic [PORTS-1:0][31:0] blk_ctr;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stall_ctr <= '0;
      blk_ctr   <= '0;
    end else begin
      if ((state == ST_IDLE) && blk_avail && !iLINK_FIFO_EMPTY && !head_credit)
        stall_ctr <= stall_ctr + 32'd1;
      if (state == ST_DONE)
        blk_ctr[cur_link] <= blk_ctr[cur_link] + 32'd1;
    end
  end

  assign oREG_STALL_CTR = stall_ctr;
  assign oREG_BLK_CTR   = blk_ctr;
`else
  assign oREG_STALL_CTR = '0;
  assign oREG_BLK_CTR   = '0;
`endif

endmodule

// File: tb/tb_tx_blk_dma_sched.sv
// tb_tx_blk_dma_sched: directed bench for tx_blk_dma_sched with a small
// upstream FIFO model, TLP-ack responder and expected-address queue.
module tb_tx_blk_dma_sched;

  localparam int PORTS = 12;
  localparam int PW    = 4;
`ifdef TX_BLK_DMA_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                   iCLK;
  logic                   iRST;
  logic                   iREG_SCHED_EN;
  logic [PORTS-1:0][63:0] iREG_RING_BASE;
  logic [PORTS-1:0][7:0]  iREG_RING_BLKS;
  logic [7:0]             iFIFO_USED;
  logic                   iFIFO_FULL;
  logic                   iFIFO_EMPTY;
  logic [255:0]           iFIFO_DATA;
  logic [PW-1:0]          iLINK_NUMBER;
  logic                   iLINK_FIFO_EMPTY;
  logic                   oFIFO_RD_ACK;
  logic                   oBLK_DONE_PULSE;
  logic                   oHIP_BLK_DONE;
  logic [PW-1:0]          oHIP_LINK_NUMBER;
  logic                   oTLP_REQ;
  logic                   iTLP_ACK;
  logic [63:0]            oTLP_ADDR;
  logic [9:0]             oTLP_LEN_DW;
  logic [255:0]           oTX_DATA;
  logic                   oTX_DATA_V;
  logic                   iTX_READY;
  logic                   iHOST_BLK_FREE;
  logic [PW-1:0]          iHOST_LINK_NUMBER;
  logic [1:0]             oREG_SCHED_PS;
  logic [31:0]            oREG_STALL_CTR;
  logic [PORTS-1:0][31:0] oREG_BLK_CTR;

  tx_blk_dma_sched #(.PORTS(PORTS), .PORT_WIDTH(PW)) dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .iREG_SCHED_EN     (iREG_SCHED_EN),
    .iREG_RING_BASE    (iREG_RING_BASE),
    .iREG_RING_BLKS    (iREG_RING_BLKS),
    .iFIFO_USED        (iFIFO_USED),
    .iFIFO_FULL        (iFIFO_FULL),
    .iFIFO_EMPTY       (iFIFO_EMPTY),
    .iFIFO_DATA        (iFIFO_DATA),
    .iLINK_NUMBER      (iLINK_NUMBER),
    .iLINK_FIFO_EMPTY  (iLINK_FIFO_EMPTY),
    .oFIFO_RD_ACK      (oFIFO_RD_ACK),
    .oBLK_DONE_PULSE   (oBLK_DONE_PULSE),
    .oHIP_BLK_DONE     (oHIP_BLK_DONE),
    .oHIP_LINK_NUMBER  (oHIP_LINK_NUMBER),
    .oTLP_REQ          (oTLP_REQ),
    .iTLP_ACK          (iTLP_ACK),
    .oTLP_ADDR         (oTLP_ADDR),
    .oTLP_LEN_DW       (oTLP_LEN_DW),
    .oTX_DATA          (oTX_DATA),
    .oTX_DATA_V        (oTX_DATA_V),
    .iTX_READY         (iTX_READY),
    .iHOST_BLK_FREE    (iHOST_BLK_FREE),
    .iHOST_LINK_NUMBER (iHOST_LINK_NUMBER),
    .oREG_SCHED_PS     (oREG_SCHED_PS),
    .oREG_STALL_CTR    (oREG_STALL_CTR),
    .oREG_BLK_CTR      (oREG_BLK_CTR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // upstream / host model
  int          avail = 0;
  logic [31:0] seq = 0;
  int          lq[$];
  logic [63:0] exp_q[$];
  int          n_ack = 0, n_done = 0, n_tlp = 0, tlp_in_blk = 0;
  int          req_cnt = 0, ack_delay = 0;
  bit          toggle_rdy = 1'b0;

  task automatic drive_fifo();
    iFIFO_EMPTY      = (avail == 0);
    iFIFO_FULL       = (avail >= 256);
    iFIFO_USED       = (avail > 255) ? 8'd255 : 8'(avail);
    iFIFO_DATA       = {8{seq}};
    iLINK_FIFO_EMPTY = (lq.size() == 0);
    iLINK_NUMBER     = (lq.size() != 0) ? PW'(lq[0]) : '0;
  endtask

  task automatic push_block(input int link);
    avail += 128;
    lq.push_back(link);
    drive_fifo();
    #1;
  endtask

  // Sample just before the edge, advance one clock, update the model, drive.
  task automatic step();
    bit acked, done, tlp_acc;
    acked   = oFIFO_RD_ACK;
    done    = oBLK_DONE_PULSE;
    tlp_acc = oTLP_REQ & iTLP_ACK;
    if (oTLP_REQ && exp_q.size() != 0)
      chk("tlp_addr", oTLP_ADDR, exp_q[0] + 64'(tlp_in_blk) * 64'd256);
    if (acked)
      chk("beat_data", oTX_DATA[63:0], {seq, seq});
    if (done) begin
      chk("hip_done", 64'(oHIP_BLK_DONE), 64'd1);
      chk("done_link", 64'(oHIP_LINK_NUMBER), (lq.size() != 0) ? 64'(lq[0]) : 64'd99);
      chk("tlps_per_blk", 64'(tlp_in_blk), 64'd16);
    end
    @(posedge iCLK);
    #1;
    if (acked) begin
      n_ack++;
      avail--;
      seq++;
    end
    if (tlp_acc) begin
      n_tlp++;
      tlp_in_blk++;
    end
    if (done) begin
      n_done++;
      tlp_in_blk = 0;
      if (lq.size() != 0) void'(lq.pop_front());
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (toggle_rdy) iTX_READY = ~iTX_READY;
    if (oTLP_REQ) begin
      iTLP_ACK = (req_cnt >= ack_delay);
      req_cnt++;
    end else begin
      iTLP_ACK = 1'b0;
      req_cnt  = 0;
    end
    drive_fifo();
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int c = 0;
    while (n_done < target && c < budget) begin
      step();
      c++;
    end
    chk(tag, 64'(n_done), 64'(target));
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    iREG_SCHED_EN  = 1'b0;
    iHOST_BLK_FREE = 1'b0;
    iTX_READY      = 1'b1;
    toggle_rdy     = 1'b0;
    ack_delay      = 0;
    avail          = 0;
    lq.delete();
    exp_q.delete();
    tlp_in_blk = 0;
    n_ack = 0; n_done = 0; n_tlp = 0;
    drive_fifo();
    step();
    step();
    iRST = 1'b0;
    step();
  endtask

  initial begin
    iRST              = 1'b1;
    iREG_SCHED_EN     = 1'b0;
    iREG_RING_BASE    = '0;
    iREG_RING_BLKS    = '0;
    iTLP_ACK          = 1'b0;
    iTX_READY         = 1'b1;
    iHOST_BLK_FREE    = 1'b0;
    iHOST_LINK_NUMBER = '0;
    drive_fifo();
    #1;
    chk("rst_ps", 64'(oREG_SCHED_PS), 64'd0);
    chk("rst_len", 64'(oTLP_LEN_DW), 64'd64);
    chk("rst_req", 64'(oTLP_REQ), 64'd0);
    chk("rst_addr", oTLP_ADDR, 64'd0);
    chk("rst_txv", 64'(oTX_DATA_V), 64'd0);
    chk("rst_rdack", 64'(oFIFO_RD_ACK), 64'd0);
    chk("rst_done", 64'(oHIP_BLK_DONE), 64'd0);
    chk("rst_stall", 64'(oREG_STALL_CTR), 64'd0);
    chk("rst_blkctr", 64'(oREG_BLK_CTR[3]), 64'd0);

    // single block on link 3, then a second block one ring slot further
    do_reset();
    iREG_RING_BASE[3] = 64'h1_0000_0000;
    iREG_RING_BLKS[3] = 8'd4;
    iREG_SCHED_EN     = 1'b1;
    exp_q.push_back(64'h1_0000_0000);
    push_block(3);
    wait_done(1, 400, "single_done");
    chk("single_acks", 64'(n_ack), 64'd128);
    chk("single_tlps", 64'(n_tlp), 64'd16);
    chk("single_blkctr", 64'(oREG_BLK_CTR[3]), STATS ? 64'd1 : 64'd0);
    chk("single_ps", 64'(oREG_SCHED_PS), 64'd0);
    exp_q.push_back(64'h1_0000_1000);
    push_block(3);
    wait_done(2, 400, "single2_done");
    chk("single2_acks", 64'(n_ack), 64'd256);

    // ring wrap on link 0, depth 2, low base bits ignored
    do_reset();
    iREG_RING_BASE[0] = 64'h2_0000_0abc;
    iREG_RING_BLKS[0] = 8'd2;
    iREG_SCHED_EN     = 1'b1;
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(64'h2_0000_0000 + ((b % 2 == 1) ? 64'h1000 : 64'h0));
      push_block(0);
      wait_done(b + 1, 400, "wrap_done");
      iHOST_BLK_FREE    = 1'b1;
      iHOST_LINK_NUMBER = 4'd0;
      step();
      iHOST_BLK_FREE    = 1'b0;
    end
    chk("wrap_acks", 64'(n_ack), 64'd384);

    // credit stall: depth 1, two blocks queued on link 5
    do_reset();
    iREG_RING_BASE[5] = 64'h0_3000_0000;
    iREG_RING_BLKS[5] = 8'd1;
    iREG_SCHED_EN     = 1'b1;
    exp_q.push_back(64'h0_3000_0000);
    exp_q.push_back(64'h0_3000_0000);
    push_block(5);
    push_block(5);
    wait_done(1, 400, "stall_first_done");
    for (int k = 0; k < 20; k++) step();
    chk("stall_ps", 64'(oREG_SCHED_PS), 64'd0);
    chk("stall_acks", 64'(n_ack), 64'd128);
    chk("stall_ctr", 64'(oREG_STALL_CTR), STATS ? 64'd20 : 64'd0);
    iHOST_BLK_FREE    = 1'b1;
    iHOST_LINK_NUMBER = 4'd5;
    step();
    iHOST_BLK_FREE    = 1'b0;
    chk("free_ps_idle", 64'(oREG_SCHED_PS), 64'd0);
    step();
    chk("free_ps_hdr", 64'(oREG_SCHED_PS), 64'd1);
    wait_done(2, 400, "stall_second_done");

    // backpressure + enable dropped mid-block
    do_reset();
    iREG_RING_BASE[7] = 64'h4_0000_0000;
    iREG_RING_BLKS[7] = 8'd0;
    iREG_SCHED_EN     = 1'b1;
    toggle_rdy        = 1'b1;
    ack_delay         = 5;
    exp_q.push_back(64'h4_0000_0000);
    push_block(7);
    for (int k = 0; k < 30; k++) step();
    iREG_SCHED_EN = 1'b0;
    wait_done(1, 1000, "bp_done");
    chk("bp_acks", 64'(n_ack), 64'd128);
    chk("bp_tlps", 64'(n_tlp), 64'd16);
    toggle_rdy = 1'b0;
    iTX_READY  = 1'b1;
    push_block(7);
    for (int k = 0; k < 10; k++) step();
    chk("halt_ps", 64'(oREG_SCHED_PS), 64'd0);
    chk("halt_done", 64'(n_done), 64'd1);

    // free and start on link 2 in the same cycle leave outstanding unchanged
    do_reset();
    iREG_RING_BASE[2] = 64'h0_5000_0000;
    iREG_RING_BLKS[2] = 8'd2;
    iREG_SCHED_EN     = 1'b1;
    exp_q.push_back(64'h0_5000_0000);
    push_block(2);
    wait_done(1, 400, "simul_a_done");
    exp_q.push_back(64'h0_5000_1000);
    push_block(2);
    iHOST_BLK_FREE    = 1'b1;
    iHOST_LINK_NUMBER = 4'd2;
    step();
    iHOST_BLK_FREE    = 1'b0;
    chk("simul_start", 64'(oREG_SCHED_PS), 64'd1);
    wait_done(2, 400, "simul_b_done");
    exp_q.push_back(64'h0_5000_0000);
    push_block(2);
    wait_done(3, 400, "simul_c_done");
    push_block(2);
    for (int k = 0; k < 20; k++) step();
    chk("simul_full_ps", 64'(oREG_SCHED_PS), 64'd0);
    chk("simul_full_done", 64'(n_done), 64'd3);

    // reset at beat 40
    do_reset();
    iREG_RING_BASE[1] = 64'h0_6000_0000;
    iREG_RING_BLKS[1] = 8'd3;
    iREG_SCHED_EN     = 1'b1;
    exp_q.push_back(64'h0_6000_0000);
    push_block(1);
    begin
      int c = 0;
      while (n_ack < 40 && c < 400) begin
        step();
        c++;
      end
    end
    chk("mid_beats", 64'(n_ack), 64'd40);
    iRST = 1'b1;
    #1;
    chk("mid_ps", 64'(oREG_SCHED_PS), 64'd0);
    chk("mid_req", 64'(oTLP_REQ), 64'd0);
    chk("mid_addr", oTLP_ADDR, 64'd0);
    chk("mid_txv", 64'(oTX_DATA_V), 64'd0);
    chk("mid_txdata", oTX_DATA[63:0], 64'd0);
    chk("mid_rdack", 64'(oFIFO_RD_ACK), 64'd0);
    chk("mid_done", 64'(oHIP_BLK_DONE), 64'd0);
    avail = 0;
    lq.delete();
    exp_q.delete();
    tlp_in_blk = 0;
    drive_fifo();
    step();
    chk("mid_ps_edge", 64'(oREG_SCHED_PS), 64'd0);
    iRST = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mid_no_done", 64'(n_done), 64'd0);
    chk("mid_idle", 64'(oREG_SCHED_PS), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
